wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage in front of the 32x32 register file. Merges single-cycle ALU results
//  with long-latency results (loads, qubit measurements) into the file's one write port.
//  Long-latency results are buffered in a small FIFO. A destination scoreboard feeds the
//  issue stage's hazard stall.
// PARAMETERS
//  XLEN        32  data width of results and rf_wd
//  FIFO_DEPTH  4   long-latency result buffer entries (power of 2, >=2)
//  STARVE_MAX  8   consecutive ALU-won cycles before FIFO is forced to drain
// PORTS
//  clk          in   1     clock
//  reset        in   1     reset, asynchronous, active-high
//  alu_valid    in   1     ALU result present this cycle
//  alu_rd       in   5     ALU destination register
//  alu_data     in   XLEN  ALU result
//  alu_stall    out  1     ALU must hold; its result is not accepted this cycle
//  ll_valid     in   1     long-latency result offered
//  ll_ready     out  1     FIFO can accept (valid&&ready = transfer)
//  ll_rd        in   5     long-latency destination register
//  ll_data      in   XLEN  long-latency result
//  issue_valid  in   1     long-latency op issued this cycle
//  issue_rd     in   5     its destination register
//  busy_mask    out  32    bit i = register i awaits a long-latency result
//  rf_we        out  1     register-file write enable (registered)
//  rf_rd        out  5     register-file write address (registered)
//  rf_wd        out  XLEN  register-file write data (registered)
// BEHAVIOUR
//  Reset: rf_we=0, rf_rd=0, rf_wd=0, busy_mask=0, FIFO empty, starve count 0.
//   alu_stall=0 and ll_ready=1 follow from the reset state.
//  Latency: a selected result appears on rf_* the cycle after selection (1 cycle).
//  Arbitration per cycle:
//   - Normal: ALU wins if alu_valid. Otherwise the FIFO head pops if non-empty.
//   - Force: starve count==STARVE_MAX and FIFO non-empty -> FIFO head pops;
//     alu_stall=1 if alu_valid. alu_stall is combinational from state and alu_valid.
//  Starve count:
//   - +1 when FIFO is non-empty and ALU wins; saturates at STARVE_MAX.
//   - Cleared on any FIFO pop or when FIFO is empty.
//  FIFO: ll_ready = !full. Push and pop in the same cycle are both allowed when full
//   (occupancy unchanged); ll_ready still reflects the pre-pop full flag.
//   Pointers wrap modulo FIFO_DEPTH.
//  rd==0 results: consumed/popped normally, but rf_we=0 for that cycle.
//  Scoreboard:
//   - issue_valid sets busy_mask[issue_rd]; ignored for rd 0.
//   - A FIFO pop clears busy_mask[head.rd].
//   - Same-cycle set and clear of the same rd: set wins (new producer outstanding).
//  Reset mid-operation: FIFO contents and busy_mask discarded immediately.
//  Ordering: FIFO entries write in arrival order. ALU results for a busy rd are the
//   issue stage's responsibility (it stalls on busy_mask).
// CONFIGURATION
//  WB_ARB_PERF_EN defined:
//   - Adds output perf_conflicts (32 bit): cycles where alu_valid and FIFO non-empty.
//   - Adds output perf_forced (32 bit): cycles where alu_stall=1.
//   - Both reset to 0 and wrap on overflow.
//  WB_ARB_PERF_EN undefined: neither port nor its counters exist.
// STRUCTURE
//  Shared package core_pkg:
//   - reg_idx_t (logic [4:0]), xlen_t
//   - wb_req_t struct {reg_idx_t rd; xlen_t data;}
//   - REG_ZERO constant
//  Sub-module wb_fifo: sync FIFO of wb_req_t with params DEPTH; ports push/pop/full/
//   empty/head. Arbitration, scoreboard and starve counter stay in wb_arbiter.
// TESTING
//  1. ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5,
//     rf_wd=0xDEADBEEF; alu_stall=0.
//  2. Fill FIFO: 4 ll pushes with alu_valid held high -> ll_ready=0 after 4th.
//     Forced pop occurs after 8 ALU-won cycles, with alu_stall=1 for that cycle.
//  3. Scoreboard: issue rd=7 -> busy_mask=0x80. The ll rd=7 result pops ->
//     busy_mask=0 the cycle after the pop and rf_rd=7. Same-cycle re-issue of rd 7
//     during the pop leaves bit 7 set.
//  4. rd=0: ALU and ll results to x0 -> rf_we stays 0; FIFO still drains;
//     busy_mask unaffected.
//  5. Full with push and pop same cycle: occupancy stays 4; entries exit in order
//     A,B,C,D,E.
//  6. Reset asserted with 3 FIFO entries and busy_mask=0x0E -> all outputs zero
//     immediately. After release no stale writes occur.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: register index, data word and writeback request.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. A push into a full FIFO is taken only
// when a pop frees the head slot in the same cycle.
module wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  wb_req_t       mem_q [DEPTH];
  logic          wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered long-latency results into the register
// file write port and tracks outstanding destinations. WB_ARB_PERF_EN adds perf counters.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     busy_mask,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]     perf_conflicts,
  output logic [31:0]     perf_forced
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_req_t       fifo_head, fifo_in;
  logic          force_drain, alu_win;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          rf_we_q, rf_we_d;
  reg_idx_t      rf_rd_q, rf_rd_d;
  xlen_t         rf_wd_q, rf_wd_d;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign fifo_in     = '{rd: ll_rd, data: ll_data};
  assign ll_ready    = !fifo_full;
  assign fifo_push   = ll_valid && ll_ready;
  assign force_drain = !fifo_empty && (starve_q == SW'(STARVE_MAX));
  assign alu_stall   = alu_valid && force_drain;
  assign alu_win     = alu_valid && !force_drain;
  assign fifo_pop    = !fifo_empty && !alu_win;

  always_comb begin
    starve_d = starve_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_wd_d  = rf_wd_q;
    busy_d   = busy_q;

    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end

    if (alu_win) begin
      rf_we_d = (alu_rd != REG_ZERO);
      rf_rd_d = alu_rd;
      rf_wd_d = alu_data;
    end else if (fifo_pop) begin
      rf_we_d = (fifo_head.rd != REG_ZERO);
      rf_rd_d = fifo_head.rd;
      rf_wd_d = fifo_head.data;
    end

    // Set after clear so a same-cycle reissue keeps the register busy.
    if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      busy_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign busy_mask = busy_q;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wd     = rf_wd_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] conflicts_q, conflicts_d;
  logic [31:0] forced_q, forced_d;

  always_comb begin
    conflicts_d = conflicts_q + {31'd0, (alu_valid && !fifo_empty)};
    forced_d    = forced_q + {31'd0, alu_stall};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflicts_q <= '0;
      forced_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      forced_q    <= forced_d;
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_forced    = forced_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic        clk, reset;
  logic        alu_valid, alu_stall, ll_valid, ll_ready, issue_valid, rf_we;
  logic [4:0]  alu_rd, ll_rd, issue_rd, rf_rd;
  logic [31:0] alu_data, ll_data, busy_mask, rf_wd;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_forced;
`endif

  wb_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_rd      (ll_rd),
    .ll_data    (ll_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy_mask  (busy_mask),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflicts(perf_conflicts),
    .perf_forced   (perf_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Model state
  ent_t        mq[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        stall_seen, ready_seen;
  logic [31:0] wr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_regs();
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      chk("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
      chk("rf_wd", rf_wd, m_wd);
    end
    chk("busy_mask", busy_mask, m_busy);
    if (rf_we === 1'b1) wr_log.push_back(rf_wd);
  endtask

  task automatic model_clear();
    mq.delete();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_wd     = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    bit   frc, pop, was_empty, rdy;
    ent_t h;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
    issue_valid = iv; issue_rd = ird;
    #1;
    was_empty = (mq.size() == 0);
    frc = (m_starve == SMAX) && !was_empty;
    pop = !was_empty && (frc || !av);
    rdy = (mq.size() < DEPTH);
    chk("alu_stall", {31'd0, alu_stall}, {31'd0, av && frc});
    chk("ll_ready", {31'd0, ll_ready}, {31'd0, rdy});
    stall_seen = alu_stall;
    ready_seen = ll_ready;
    if (av && !frc) begin
      m_we = (ard != 0); m_rd = ard; m_wd = ad;
    end else if (pop) begin
      h = mq.pop_front();
      m_we = (h.rd != 0); m_rd = h.rd; m_wd = h.data;
      m_busy[h.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (was_empty || pop) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    if (lv && rdy) mq.push_back('{rd: lrd, data: ld});
    @(posedge clk);
    @(negedge clk);
    compare_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    ll_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_ll_ready", {31'd0, ll_ready}, 32'd1);
    chk("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
    model_clear();
    alu_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          first_stall;
    bit          e_done;
    logic [31:0] exp_seq[5];
    reset = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    issue_valid = 0; issue_rd = 0;
    @(negedge clk);
    do_reset();

    // ALU only
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("t1_we", {31'd0, rf_we}, 32'd1);
    chk("t1_rd", {27'd0, rf_rd}, 32'd5);
    chk("t1_wd", rf_wd, 32'hDEADBEEF);
    idle(2);

    // Fill FIFO under continuous ALU traffic; forced drain after 8 ALU wins
    first_stall = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 5'(i + 1), 32'h100 + i, i < 4, 5'(10 + i), 32'h200 + i, 0, 0);
      if (i == 4) chk("t2_ready_full", {31'd0, ready_seen}, 32'd0);
      if (stall_seen && first_stall < 0) first_stall = i;
    end
    chk("t2_force_cycle", first_stall, 32'd9);
    idle(8);

    // Scoreboard
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    chk("t3_busy_set", busy_mask, 32'h80);
    cycle(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_pop_rd", {27'd0, rf_rd}, 32'd7);
    chk("t3_busy_clr", busy_mask, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(0, 0, 0, 1, 5'd7, 32'h78, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    chk("t3_reissue", busy_mask, 32'h80);
    cycle(0, 0, 0, 1, 5'd7, 32'h79, 0, 0);
    idle(2);
    chk("t3_final", busy_mask, 32'h0);

    // Writes to x0
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd3);
    cycle(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 0, 0);
    chk("t4_alu_x0", {31'd0, rf_we}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_ll_x0", {31'd0, rf_we}, 32'd0);
    chk("t4_busy", busy_mask, 32'h08);
    cycle(0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
    idle(3);

    // Full FIFO, ordering A..E
    for (int i = 0; i < 4; i++) cycle(1, 5'd20, 32'h0, 1, 5'd12, 32'hA + i, 0, 0);
    wr_log.delete();
    e_done = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, !e_done, 5'd12, 32'hE, 0, 0);
      if (ready_seen) e_done = 1;
    end
    exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    chk("t5_count", wr_log.size(), 32'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("t5_order", wr_log[i], exp_seq[i]);

    // Reset mid-operation
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd2);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd3);
    for (int i = 0; i < 3; i++) cycle(1, 5'd9, 32'h55, 1, 5'(1 + i), 32'h60 + i, 0, 0);
    chk("t6_pre_busy", busy_mask, 32'h0E);
    do_reset();
    wr_log.delete();
    idle(6);
    chk("t6_no_stale", wr_log.size(), 32'd0);

    // Randomised traffic with varying densities
    for (int seg = 0; seg < 8; seg++) begin
      int pa, pl;
      pa = $urandom_range(10, 95);
      pl = $urandom_range(10, 90);
      for (int i = 0; i < 300; i++) begin
        cycle($urandom_range(0, 99) < pa, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 99) < pl, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)));
      end
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
